// File: rtl/rr_arbiter_n_if.sv
// rr_arbiter_n_if: request/grant bundle; master drives en/req/lock and observes grants, slave is the arbiter
interface rr_arbiter_n_if #(
  parameter int NUM_REQ = 8
);
  localparam int IW = $clog2(NUM_REQ);
  logic               en;
  logic [NUM_REQ-1:0] req;
  logic               lock;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_valid;
  logic               req_up;
  logic               holding;
  modport master (output en, req, lock, input gnt, gnt_idx, gnt_valid, req_up, holding);
  modport slave  (input en, req, lock, output gnt, gnt_idx, gnt_valid, req_up, holding);
endinterface

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin arbiter with optional bounded grant locking (RR_ARB_LOCK_EN); ports clock, reset, bus (rr_arbiter_n_if.slave: en/req/lock in, gnt/gnt_idx/gnt_valid/req_up/holding out)
module rr_arbiter_n #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 4
) (
  input logic           clock,
  input logic           reset,
  rr_arbiter_n_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0]          ptr_q, ptr_d, pick, off, win;
  logic [2*NUM_REQ-1:0]   dbl;
  logic                   hold_go, any, live;
  assign dbl = {bus.req, bus.req} >> ptr_q;
  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) off = dbl[k] ? IW'(k) : off;
  end
  assign pick = ptr_q + off;
`ifdef RR_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enter, rel;
  assign hold_go = state_q == HOLD && bus.req[owner_q] && bus.lock;
  assign win     = hold_go ? owner_q : pick;
  assign enter   = bus.en && !hold_go && bus.lock && |bus.req && (MAX_HOLD > 1);
  assign rel     = hold_go && (cnt_q + CW'(1) == CW'(MAX_HOLD));
  always_comb begin
    state_d = !bus.en ? state_q : (enter || (hold_go && !rel)) ? HOLD : IDLE;
    owner_d = enter ? pick : owner_q;
    cnt_d   = enter ? CW'(1) : (bus.en && hold_go) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.holding = state_q == HOLD && !reset;
`else
  logic unused_lock;
  assign unused_lock = bus.lock;
  assign hold_go     = 1'b0;
  assign win         = pick;
  assign bus.holding = 1'b0;
`endif
  assign any  = hold_go || |bus.req;
  assign live = bus.en && !reset && any;
  // the pointer only moves on a fresh pick; a continuing tenure leaves it at owner+1
  assign ptr_d = (bus.en && any && !hold_go) ? pick + IW'(1) : ptr_q;
  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
  assign bus.gnt       = live ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
  assign bus.gnt_idx   = live ? win : '0;
  assign bus.gnt_valid = live;
  assign bus.req_up    = |bus.req;
endmodule
